// File: rtl/shl_share_pkg.sv
// Shared helpers for the shl sharing arbiter.
// Width derivation and packed-bus lane addressing.
package shl_share_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int tag_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/shl_share_arbiter_rr.sv
// Combinational round-robin picker.
// Returns the first requester at or after ptr, as one-hot and index.
module rr_arbiter
  import shl_share_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [tag_w(NUM_REQ)-1:0]   ptr,
  input  logic                        en,
  output logic [NUM_REQ-1:0]          grant,
  output logic [tag_w(NUM_REQ)-1:0]   idx,
  output logic                        any
);

  localparam int TAG_W = tag_w(NUM_REQ);

  logic [TAG_W-1:0] k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      k = TAG_W'((int'(ptr) + off) % NUM_REQ);
      if (en && !any && req[k]) begin
        grant[k] = 1'b1;
        idx      = k;
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shl_share_arbiter.sv
// One left shifter shared round-robin by NUM_REQ requesters.
// SHL_SHARE_PIPE_EN adds an operand stage (latency 2).
module shl_share_arbiter
  import shl_share_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_TYPE = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   ins_lhs,
  input  logic [NUM_REQ-1:0]             ins_lhs_valid,
  output logic [NUM_REQ-1:0]             ins_lhs_ready,
  input  logic [NUM_REQ*DATA_TYPE-1:0]   ins_rhs,
  input  logic [NUM_REQ-1:0]             ins_rhs_valid,
  output logic [NUM_REQ-1:0]             ins_rhs_ready,
  output logic [NUM_REQ*DATA_TYPE-1:0]   outs,
  output logic [NUM_REQ-1:0]             outs_valid,
  input  logic [NUM_REQ-1:0]             outs_ready
);

  localparam int TAG_W = tag_w(NUM_REQ);

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   gnt;
  logic [TAG_W-1:0]     gnt_idx;
  logic                 gnt_any;
  logic                 arb_en;
  logic [TAG_W-1:0]     ptr;
  logic [DATA_TYPE-1:0] gnt_lhs;
  logic [DATA_TYPE-1:0] gnt_rhs;

  logic                 slot_valid;
  logic [TAG_W-1:0]     slot_tag;
  logic [DATA_TYPE-1:0] slot_data;
  logic                 slot_free;

  logic                 src_valid;
  logic [TAG_W-1:0]     src_tag;
  logic [DATA_TYPE-1:0] src_lhs;
  logic [DATA_TYPE-1:0] src_rhs;

  function automatic logic [DATA_TYPE-1:0] shl(
    input logic [DATA_TYPE-1:0] a,
    input logic [DATA_TYPE-1:0] b
  );
    return (b >= DATA_TYPE'(DATA_TYPE)) ? '0 : (a << b);
  endfunction

  assign eligible  = ins_lhs_valid & ins_rhs_valid;
  assign slot_free = !slot_valid || outs_ready[slot_tag];

  assign gnt_lhs = ins_lhs[lane_lsb(int'(gnt_idx), DATA_TYPE) +: DATA_TYPE];
  assign gnt_rhs = ins_rhs[lane_lsb(int'(gnt_idx), DATA_TYPE) +: DATA_TYPE];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req   (eligible),
    .ptr   (ptr),
    .en    (arb_en),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign ins_lhs_ready = gnt;
  assign ins_rhs_ready = gnt;

`ifdef SHL_SHARE_PIPE_EN
  logic                 stg_valid;
  logic [TAG_W-1:0]     stg_tag;
  logic [DATA_TYPE-1:0] stg_lhs;
  logic [DATA_TYPE-1:0] stg_rhs;
  logic                 stg_free;

  // Stage accepts when empty or moving into the slot this cycle.
  assign stg_free = !stg_valid || slot_free;
  assign arb_en   = !rst && stg_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_tag   <= '0;
      stg_lhs   <= '0;
      stg_rhs   <= '0;
    end else if (stg_free) begin
      stg_valid <= gnt_any;
      if (gnt_any) begin
        stg_tag <= gnt_idx;
        stg_lhs <= gnt_lhs;
        stg_rhs <= gnt_rhs;
      end
    end
  end

  assign src_valid = stg_valid;
  assign src_tag   = stg_tag;
  assign src_lhs   = stg_lhs;
  assign src_rhs   = stg_rhs;
`else
  assign arb_en    = !rst && slot_free;
  assign src_valid = gnt_any;
  assign src_tag   = gnt_idx;
  assign src_lhs   = gnt_lhs;
  assign src_rhs   = gnt_rhs;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Data and tag only move on a load, so a stalled or drained slot holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= 1'b0;
      slot_tag   <= '0;
      slot_data  <= '0;
    end else if (slot_free) begin
      slot_valid <= src_valid;
      if (src_valid) begin
        slot_tag  <= src_tag;
        slot_data <= shl(src_lhs, src_rhs);
      end
    end
  end

  always_comb begin
    outs_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      outs_valid[i] = slot_valid && (slot_tag == TAG_W'(i));
    end
  end

  assign outs = {NUM_REQ{slot_data}};

endmodule

// File: tb/tb_shl_share_arbiter.sv
// Directed bench for shl_share_arbiter (NUM_REQ=2, DATA_TYPE=32).
// Table of per-cycle vectors plus reset sequences.
module tb_shl_share_arbiter;

  logic        clk;
  logic        rst;
  logic [63:0] ins_lhs;
  logic [1:0]  ins_lhs_valid;
  logic [1:0]  ins_lhs_ready;
  logic [63:0] ins_rhs;
  logic [1:0]  ins_rhs_valid;
  logic [1:0]  ins_rhs_ready;
  logic [63:0] outs;
  logic [1:0]  outs_valid;
  logic [1:0]  outs_ready;

  int checks = 0;
  int errors = 0;

  shl_share_arbiter #(
    .NUM_REQ   (2),
    .DATA_TYPE (32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ins_lhs       (ins_lhs),
    .ins_lhs_valid (ins_lhs_valid),
    .ins_lhs_ready (ins_lhs_ready),
    .ins_rhs       (ins_rhs),
    .ins_rhs_valid (ins_rhs_valid),
    .ins_rhs_ready (ins_rhs_ready),
    .outs          (outs),
    .outs_valid    (outs_valid),
    .outs_ready    (outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lhs0;
    logic [31:0] rhs0;
    logic [31:0] lhs1;
    logic [31:0] rhs1;
    logic [1:0]  lv;
    logic [1:0]  rv;
    logic [1:0]  ordy;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_ov;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ins_lhs       = {v.lhs1, v.lhs0};
    ins_rhs       = {v.rhs1, v.rhs0};
    ins_lhs_valid = v.lv;
    ins_rhs_valid = v.rv;
    outs_ready    = v.ordy;
  endtask

  initial begin
    // lhs0 rhs0 lhs1 rhs1 lv rv ordy | rdy ov out
    vecs[0]  = '{32'h1, 32'd4, 32'h0, 32'd0, 2'b01, 2'b01, 2'b11,
                 2'b01, 2'b01, 32'h10};
    vecs[1]  = '{32'h3, 32'd1, 32'h5, 32'd2, 2'b11, 2'b11, 2'b11,
                 2'b10, 2'b10, 32'h14};
    vecs[2]  = '{32'h3, 32'd1, 32'h5, 32'd2, 2'b11, 2'b11, 2'b11,
                 2'b01, 2'b01, 32'h6};
    vecs[3]  = '{32'h3, 32'd1, 32'h5, 32'd2, 2'b11, 2'b11, 2'b11,
                 2'b10, 2'b10, 32'h14};
    vecs[4]  = '{32'hFFFF_FFFF, 32'd31, 32'h0, 32'd0, 2'b01, 2'b01, 2'b11,
                 2'b01, 2'b01, 32'h8000_0000};
    vecs[5]  = '{32'hFFFF_FFFF, 32'd32, 32'h0, 32'd0, 2'b01, 2'b01, 2'b11,
                 2'b01, 2'b01, 32'h0};
    vecs[6]  = '{32'h0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b10, 2'b10,
                 2'b11, 2'b10, 2'b10, 32'h0};
    vecs[7]  = '{32'h0, 32'd0, 32'h9, 32'd1, 2'b10, 2'b00, 2'b11,
                 2'b00, 2'b00, 32'h0};
    vecs[8]  = '{32'h0, 32'd0, 32'h7, 32'd4, 2'b10, 2'b10, 2'b00,
                 2'b10, 2'b10, 32'h70};
    vecs[9]  = '{32'h2, 32'd3, 32'h0, 32'd0, 2'b01, 2'b01, 2'b00,
                 2'b00, 2'b10, 32'h70};
    vecs[10] = '{32'h2, 32'd3, 32'h0, 32'd0, 2'b01, 2'b01, 2'b01,
                 2'b00, 2'b10, 32'h70};
    vecs[11] = '{32'h2, 32'd3, 32'h0, 32'd0, 2'b01, 2'b01, 2'b00,
                 2'b00, 2'b10, 32'h70};
    vecs[12] = '{32'h2, 32'd3, 32'h0, 32'd0, 2'b01, 2'b01, 2'b10,
                 2'b01, 2'b01, 32'h10};
    vecs[13] = '{32'h0, 32'd0, 32'h0, 32'd0, 2'b00, 2'b00, 2'b11,
                 2'b00, 2'b00, 32'h10};

    rst           = 1'b1;
    ins_lhs       = {32'h5, 32'h5};
    ins_rhs       = {32'h1, 32'h1};
    ins_lhs_valid = 2'b11;
    ins_rhs_valid = 2'b11;
    outs_ready    = 2'b11;
    #12;
    chk("rst_lhs_ready", 64'(ins_lhs_ready), 64'd0);
    chk("rst_rhs_ready", 64'(ins_rhs_ready), 64'd0);
    chk("rst_outs_valid", 64'(outs_valid), 64'd0);
    chk("rst_outs", outs, 64'd0);
    ins_lhs_valid = 2'b00;
    ins_rhs_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_lhs_ready", i), 64'(ins_lhs_ready),
          64'(vecs[i].exp_rdy));
      chk($sformatf("v%0d_rhs_ready", i), 64'(ins_rhs_ready),
          64'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_outs_valid", i), 64'(outs_valid),
          64'(vecs[i].exp_ov));
      chk($sformatf("v%0d_lane0", i), 64'(outs[31:0]),
          64'(vecs[i].exp_out));
      chk($sformatf("v%0d_lane1", i), 64'(outs[63:32]),
          64'(vecs[i].exp_out));
    end

    // Load a stalled result with the pointer at 1, then reset mid-cycle.
    ins_lhs       = {32'h0, 32'h1};
    ins_rhs       = {32'h0, 32'd5};
    ins_lhs_valid = 2'b01;
    ins_rhs_valid = 2'b01;
    outs_ready    = 2'b00;
    @(posedge clk);
    #1;
    chk("pre_rst_outs_valid", 64'(outs_valid), 64'h1);
    chk("pre_rst_lane0", 64'(outs[31:0]), 64'h20);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs_valid", 64'(outs_valid), 64'd0);
    chk("async_rst_outs", outs, 64'd0);
    chk("async_rst_ready", 64'(ins_lhs_ready), 64'd0);
    #2;
    rst = 1'b0;
    ins_lhs       = {32'h1, 32'h3};
    ins_rhs       = {32'd1, 32'd2};
    ins_lhs_valid = 2'b11;
    ins_rhs_valid = 2'b11;
    outs_ready    = 2'b11;
    #1;
    chk("post_rst_priority", 64'(ins_lhs_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("post_rst_outs_valid", 64'(outs_valid), 64'h1);
    chk("post_rst_lane0", 64'(outs[31:0]), 64'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shl_share_arbiter.md
Name: shl_share_arbiter

Overview:
Shares one left-shift datapath (result = lhs << rhs) among NUM_REQ dataflow requesters. Each requester presents a joined lhs/rhs operand pair with valid/ready handshakes and gets its result back on its own output channel. Round-robin arbitration picks one requester per cycle. A one-entry tagged result register decouples the shifter from downstream back-pressure. Sits in the elastic datapath wherever the scheduler maps several shl operations onto one shifter.

Parameters:
NUM_REQ, 2, number of requesters sharing the shifter (>=2)
DATA_TYPE, 32, operand and result width in bits

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
ins_lhs  input  NUM_REQ*DATA_TYPE  packed lhs operands; requester i occupies bits [i*DATA_TYPE +: DATA_TYPE]
ins_lhs_valid  input  NUM_REQ  lhs valid per requester
ins_lhs_ready  output  NUM_REQ  lhs ready per requester
ins_rhs  input  NUM_REQ*DATA_TYPE  packed shift amounts, same packing as ins_lhs
ins_rhs_valid  input  NUM_REQ  rhs valid per requester
ins_rhs_ready  output  NUM_REQ  rhs ready per requester
outs  output  NUM_REQ*DATA_TYPE  packed results; every lane carries the slot data
outs_valid  output  NUM_REQ  result valid per requester
outs_ready  input  NUM_REQ  downstream ready per requester

Behaviour:
- Clock is clk. Reset rst is asynchronous and active-high.
- Reset values: slot_valid=0, slot_tag=0, slot_data=0, round-robin pointer=0 (requester 0 has highest priority). All outs_valid=0 and all outs=0. The ready outputs are combinational and are 0 during reset.
- Requester i is eligible when ins_lhs_valid[i] & ins_rhs_valid[i] (join).
- A slot is free when slot_valid=0, or when slot_valid=1 and outs_ready[slot_tag]=1 (drains this cycle).
- Grant rule: when the slot is free and at least one requester is eligible, grant the first eligible requester g, searching circularly from the pointer.
- ins_lhs_ready[g] = ins_rhs_ready[g] = 1 only for the granted requester. All other ready bits are 0, and ready is never asserted to a non-eligible requester.
- At the next edge after a grant: slot_data <= lhs[g] << rhs[g], slot_tag <= g, slot_valid <= 1, pointer <= (g+1) mod NUM_REQ.
- The pointer changes only on a grant.
- If the slot drains and no grant occurs in the same cycle, slot_valid <= 0. slot_data holds its value.
- Drain and new grant in the same cycle: the slot reloads and throughput stays at 1 result/cycle.
- outs_valid[i] = slot_valid & (slot_tag == i). All outs lanes carry slot_data.
- Latency: 1 cycle from accepted handshake to outs_valid.
- Arithmetic: rhs is used at full DATA_TYPE width, unsigned. Any rhs >= DATA_TYPE yields 0. The result is truncated to DATA_TYPE bits.
- A stalled slot holds data and tag stable until drained.
- An asynchronous reset mid-operation discards the slot contents and resets the pointer.
- Starvation-free: any continuously eligible requester is granted within NUM_REQ grants.

Optional Feature:
SHL_SHARE_PIPE_EN
- Defined: adds an operand stage (lhs, rhs, tag, valid) ahead of the shifter, so latency becomes 2 cycles.
  - The operand stage advances into the result slot when the slot is free.
  - Grants occur when the operand stage is empty or advancing in the same cycle.
  - Full throughput is preserved; reset clears both stages.
- Undefined: single result slot as specified above, latency 1.

Decomposition:
- Package shl_share_pkg holds:
  - the clog2 function;
  - the TAG_W = max(1, clog2(NUM_REQ)) derivation helper;
  - the lane-slice helper function for packed buses.
- Sub-module rr_arbiter (parameter NUM_REQ) is natural. It is purely combinational:
  - inputs: req vector, pointer, enable;
  - outputs: one-hot grant plus encoded index.
- The top holds the pointer, the slot and the optional stage.

Test Plan:
- Reset, then lhs0=0x1, rhs0=4, valid on requester 0 only → ins_lhs_ready[0]=1 that cycle; next cycle outs_valid=2'b01, outs lane = 0x10.
- NUM_REQ=2, both eligible every cycle, all outs_ready=1 → grants alternate 0,1,0,1; one result per cycle, tags match requester order.
- Requester 1 result pending with outs_ready[1]=0 for 3 cycles, requester 0 eligible → no ready asserted and slot stable (data, tag=1); on release, slot drains and requester 0 is granted in the same cycle.
- lhs=0xFFFFFFFF with rhs=31 → 0x80000000; rhs=32 → 0; rhs=0xFFFFFFFF → 0.
- Only ins_lhs_valid[1]=1 with ins_rhs_valid[1]=0 → ins_lhs_ready[1] stays 0 and no grant is made.
- rst pulsed asynchronously mid-cycle while the slot is valid → outs_valid drops to 0 immediately; after release requester 0 has priority.
